// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, optional two's-complement mode.
// Operates on magnitudes, then applies the result sign in a final FIX cycle.
module seq_shift_add_multiplier #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted only on a rising edge where the FSM is IDLE
  // (busy=0); done pulses for one cycle when product has just been updated.
  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;

  always_comb begin
    sgn   = is_signed & SIGNED_EN;
    // The most negative value negates to itself, which read unsigned is its magnitude.
    abs_a = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
    abs_b = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;

    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          acc_d    = '0;
          count_d  = '0;
          neg_d    = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end
      end
      S_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        product_d = neg_q ? -acc_q : acc_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_q == S_FIX);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  assign state_dbg = state_q;

endmodule
